// File: rtl/rf_fetch_p.sv
// Register-fetch pipeline stage: 32-entry register file with synchronous read,
// write-through, prioritised operand forwarding and a load-use interlock.
module rf_fetch_p #(
  parameter int DW      = 32,
  parameter int NFWD    = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               pause,
  input  logic               hold_i,
  input  logic               clr_i,
  input  logic [31:0]        ins_i,
  input  logic               ins_vld_i,
  input  logic               wb_we_i,
  input  logic [4:0]         wb_addr_i,
  input  logic [DW-1:0]      wb_din_i,
  input  logic [NFWD-1:0]    fw_vld_i,
  input  logic [NFWD-1:0]    fw_ld_i,
  input  logic [NFWD*5-1:0]  fw_addr_i,
  input  logic [NFWD*DW-1:0] fw_data_i,
  output logic [31:0]        ins_o,
  output logic               vld_o,
  output logic [4:0]         rs_n_o,
  output logic [4:0]         rt_n_o,
  output logic [DW-1:0]      rs_o,
  output logic [DW-1:0]      rt_o,
  output logic               stall_o,
  output logic [15:0]        stall_cnt_o
);

  logic [DW-1:0] r_rf [32];
  logic [31:0]   r_ins;
  logic          r_vld;
  logic [DW-1:0] r_rs_cap;
  logic [DW-1:0] r_rt_cap;
  logic [15:0]   r_stall_cnt;

  logic          w_wr;
  logic          w_hold;
  logic          w_stall;
  logic [4:0]    w_rs_n;
  logic [4:0]    w_rt_n;
  logic [4:0]    w_rs_in;
  logic [4:0]    w_rt_in;
  logic [DW-1:0] w_rs;
  logic [DW-1:0] w_rt;
  logic          w_rs_ld;
  logic          w_rt_ld;

  assign w_rs_n  = r_ins[25:21];
  assign w_rt_n  = r_ins[20:16];
  assign w_rs_in = ins_i[25:21];
  assign w_rt_in = ins_i[20:16];
  assign w_wr    = wb_we_i && !((ZERO_R0 != 0) && (wb_addr_i == 5'd0));
  assign w_hold  = pause | hold_i | w_stall;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (w_wr) begin
      r_rf[wb_addr_i] <= wb_din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i || clr_i) begin
      r_ins    <= '0;
      r_vld    <= 1'b0;
      r_rs_cap <= '0;
      r_rt_cap <= '0;
    end else if (w_hold) begin
      // Held operands track write-back so they are current when the stage resumes
      if (w_wr && (wb_addr_i == w_rs_n)) r_rs_cap <= wb_din_i;
      if (w_wr && (wb_addr_i == w_rt_n)) r_rt_cap <= wb_din_i;
    end else begin
      r_ins    <= ins_i;
      r_vld    <= ins_vld_i;
      r_rs_cap <= (w_wr && (wb_addr_i == w_rs_in)) ? wb_din_i : r_rf[w_rs_in];
      r_rt_cap <= (w_wr && (wb_addr_i == w_rt_in)) ? wb_din_i : r_rf[w_rt_in];
    end
  end

  // Scan oldest to youngest so the lowest-index match is applied last and wins
  always_comb begin
    w_rs    = r_rs_cap;
    w_rt    = r_rt_cap;
    w_rs_ld = 1'b0;
    w_rt_ld = 1'b0;
    for (int unsigned k = NFWD; k >= 1; k--) begin
      if (fw_vld_i[k-1] && (fw_addr_i[(k-1)*5 +: 5] == w_rs_n)) begin
        w_rs    = fw_data_i[(k-1)*DW +: DW];
        w_rs_ld = fw_ld_i[k-1];
      end
      if (fw_vld_i[k-1] && (fw_addr_i[(k-1)*5 +: 5] == w_rt_n)) begin
        w_rt    = fw_data_i[(k-1)*DW +: DW];
        w_rt_ld = fw_ld_i[k-1];
      end
    end
    if ((ZERO_R0 != 0) && (w_rs_n == 5'd0)) begin
      w_rs    = '0;
      w_rs_ld = 1'b0;
    end
    if ((ZERO_R0 != 0) && (w_rt_n == 5'd0)) begin
      w_rt    = '0;
      w_rt_ld = 1'b0;
    end
  end

  assign w_stall = r_vld & (w_rs_ld | w_rt_ld);

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !pause && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign ins_o       = r_ins;
  assign vld_o       = r_vld;
  assign rs_n_o      = w_rs_n;
  assign rt_n_o      = w_rt_n;
  assign rs_o        = w_rs;
  assign rt_o        = w_rt;
  assign stall_o     = w_stall;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_rf_fetch_p.sv
// Self-checking bench for rf_fetch_p: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the stage.
module tb_rf_fetch_p;
  localparam int DW   = 32;
  localparam int NFWD = 2;

  logic               clk;
  logic               rst_i, pause, hold_i, clr_i;
  logic [31:0]        ins_i;
  logic               ins_vld_i;
  logic               wb_we_i;
  logic [4:0]         wb_addr_i;
  logic [DW-1:0]      wb_din_i;
  logic [NFWD-1:0]    fw_vld_i, fw_ld_i;
  logic [NFWD*5-1:0]  fw_addr_i;
  logic [NFWD*DW-1:0] fw_data_i;
  logic [31:0]        ins_o;
  logic               vld_o;
  logic [4:0]         rs_n_o, rt_n_o;
  logic [DW-1:0]      rs_o, rt_o;
  logic               stall_o;
  logic [15:0]        stall_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  rf_fetch_p #(.DW(DW), .NFWD(NFWD), .ZERO_R0(1)) dut (
    .clk(clk), .rst_i(rst_i), .pause(pause), .hold_i(hold_i), .clr_i(clr_i),
    .ins_i(ins_i), .ins_vld_i(ins_vld_i),
    .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_din_i(wb_din_i),
    .fw_vld_i(fw_vld_i), .fw_ld_i(fw_ld_i), .fw_addr_i(fw_addr_i), .fw_data_i(fw_data_i),
    .ins_o(ins_o), .vld_o(vld_o), .rs_n_o(rs_n_o), .rt_n_o(rt_n_o),
    .rs_o(rs_o), .rt_o(rt_o), .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic [DW-1:0] m_rf [32];
  logic [31:0]   m_ins;
  logic          m_vld;
  logic [DW-1:0] m_rs, m_rt;
  int            m_cnt;

  function automatic logic [31:0] mk_ins(input logic [4:0] rs, input logic [4:0] rt);
    logic [31:0] v;
    v = $urandom;
    v[25:21] = rs;
    v[20:16] = rt;
    return v;
  endfunction

  // Operand as seen by the consumer: register 0 is zero, else first matching source
  task automatic m_operand(input logic [4:0] a, input logic [DW-1:0] cap,
                           output logic [DW-1:0] v, output bit ld);
    v  = cap;
    ld = 1'b0;
    if (a == 5'd0) begin
      v = '0;
      return;
    end
    for (int i = 0; i < NFWD; i++) begin
      if (fw_vld_i[i] && fw_addr_i[i*5 +: 5] == a) begin
        v  = fw_data_i[i*DW +: DW];
        ld = fw_ld_i[i];
        break;
      end
    end
  endtask

  task automatic idle();
    rst_i = 0; pause = 0; hold_i = 0; clr_i = 0;
    ins_i = '0; ins_vld_i = 0;
    wb_we_i = 0; wb_addr_i = '0; wb_din_i = '0;
    fw_vld_i = '0; fw_ld_i = '0; fw_addr_i = '0; fw_data_i = '0;
  endtask

  task automatic set_fw(input int i, input bit v, input bit ld,
                        input logic [4:0] a, input logic [DW-1:0] d);
    fw_vld_i[i] = v;
    fw_ld_i[i]  = ld;
    fw_addr_i[i*5 +: 5]   = a;
    fw_data_i[i*DW +: DW] = d;
  endtask

  // One clock: compare DUT with model before the edge, then advance the model
  task automatic tick(input bit chk);
    logic [DW-1:0] e_rs, e_rt;
    bit l_rs, l_rt, e_stall, wr, hold;
    logic [DW-1:0] old_rs, old_rt;
    #1;
    m_operand(m_ins[25:21], m_rs, e_rs, l_rs);
    m_operand(m_ins[20:16], m_rt, e_rt, l_rt);
    e_stall = m_vld && (l_rs || l_rt);
    if (chk) begin
      n_chk += 8;
      if (ins_o !== m_ins) begin n_fail++; $display("FAIL ins_o: got %h expected %h", ins_o, m_ins); end
      if (vld_o !== m_vld) begin n_fail++; $display("FAIL vld_o: got %b expected %b", vld_o, m_vld); end
      if (rs_n_o !== m_ins[25:21]) begin n_fail++; $display("FAIL rs_n_o: got %h expected %h", rs_n_o, m_ins[25:21]); end
      if (rt_n_o !== m_ins[20:16]) begin n_fail++; $display("FAIL rt_n_o: got %h expected %h", rt_n_o, m_ins[20:16]); end
      if (rs_o !== e_rs) begin n_fail++; $display("FAIL rs_o: got %h expected %h", rs_o, e_rs); end
      if (rt_o !== e_rt) begin n_fail++; $display("FAIL rt_o: got %h expected %h", rt_o, e_rt); end
      if (stall_o !== e_stall) begin n_fail++; $display("FAIL stall_o: got %b expected %b", stall_o, e_stall); end
      if (stall_cnt_o !== 16'(m_cnt)) begin n_fail++; $display("FAIL stall_cnt_o: got %0d expected %0d", stall_cnt_o, m_cnt); end
    end
    @(posedge clk);
    wr   = wb_we_i && wb_addr_i != 5'd0;
    hold = pause || hold_i || e_stall;
    old_rs = m_rf[ins_i[25:21]];
    old_rt = m_rf[ins_i[20:16]];
    if (rst_i) begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_ins = '0; m_vld = 0; m_rs = '0; m_rt = '0; m_cnt = 0;
    end else begin
      if (e_stall && !pause && m_cnt < 65535) m_cnt++;
      if (clr_i) begin
        m_ins = '0; m_vld = 0; m_rs = '0; m_rt = '0;
      end else if (hold) begin
        if (wr && wb_addr_i == m_ins[25:21]) m_rs = wb_din_i;
        if (wr && wb_addr_i == m_ins[20:16]) m_rt = wb_din_i;
      end else begin
        m_ins = ins_i;
        m_vld = ins_vld_i;
        m_rs  = (wr && wb_addr_i == ins_i[25:21]) ? wb_din_i : old_rs;
        m_rt  = (wr && wb_addr_i == ins_i[20:16]) ? wb_din_i : old_rt;
      end
      if (wr) m_rf[wb_addr_i] = wb_din_i;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1;
    tick(0);
    rst_i = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1; pause = 1; clr_i = 1; ins_i = $urandom; ins_vld_i = 1;
    wb_we_i = 1; wb_addr_i = 5'd4; wb_din_i = $urandom;
    tick(0);
    idle();
    tick(1);
    n_chk += 4;
    if (vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", vld_o); end
    if (rs_o !== '0) begin n_fail++; $display("FAIL reset_rs: got %h expected 0", rs_o); end
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
    if (stall_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt_o); end
  endtask

  task automatic test_write_through();
    idle();
    wb_we_i = 1; wb_addr_i = 5'd5; wb_din_i = 32'h1234;
    ins_i = mk_ins(5'd5, 5'd6); ins_vld_i = 1;
    tick(1);
    idle();
    #1;
    n_chk++;
    if (rs_o !== 32'h1234) begin n_fail++; $display("FAIL write_through: got %h expected 00001234", rs_o); end
    tick(1);
  endtask

  task automatic test_fwd_priority();
    idle();
    ins_i = mk_ins(5'd7, 5'd8); ins_vld_i = 1;
    tick(1);
    set_fw(0, 1, 0, 5'd7, 32'hAAAA);
    set_fw(1, 1, 0, 5'd7, 32'hBBBB);
    #1;
    n_chk++;
    if (rs_o !== 32'hAAAA) begin n_fail++; $display("FAIL fwd_prio: got %h expected 0000aaaa", rs_o); end
    tick(1);
    fw_vld_i[0] = 0;
    #1;
    n_chk++;
    if (rs_o !== 32'hBBBB) begin n_fail++; $display("FAIL fwd_fallback: got %h expected 0000bbbb", rs_o); end
    tick(1);
    // Shadowed load result on the lower-priority source must not interlock
    set_fw(0, 1, 0, 5'd8, 32'h1111);
    set_fw(1, 1, 1, 5'd8, 32'h2222);
    #1;
    n_chk++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL fwd_shadow: got %b expected 0", stall_o); end
    tick(1);
  endtask

  task automatic test_load_use();
    logic [31:0] held;
    do_reset();
    held = mk_ins(5'd2, 5'd3);
    ins_i = held; ins_vld_i = 1;
    tick(1);
    ins_i = mk_ins(5'd9, 5'd10);
    set_fw(0, 1, 1, 5'd3, 32'h0000_0777);
    tick(1);
    tick(1);
    fw_ld_i[0] = 0;
    #1;
    n_chk += 3;
    if (stall_cnt_o !== 16'd2) begin n_fail++; $display("FAIL load_use_cnt: got %0d expected 2", stall_cnt_o); end
    if (ins_o !== held) begin n_fail++; $display("FAIL load_use_hold: got %h expected %h", ins_o, held); end
    if (rt_o !== 32'h777) begin n_fail++; $display("FAIL load_use_fwd: got %h expected 00000777", rt_o); end
    tick(1);
  endtask

  task automatic test_zero_reg();
    idle();
    ins_i = mk_ins(5'd0, 5'd1); ins_vld_i = 1;
    tick(1);
    set_fw(0, 1, 1, 5'd0, 32'hFFFF);
    #1;
    n_chk += 2;
    if (rs_o !== '0) begin n_fail++; $display("FAIL zero_rs: got %h expected 0", rs_o); end
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL zero_stall: got %b expected 0", stall_o); end
    tick(1);
  endtask

  task automatic test_hold_refresh();
    idle();
    ins_i = mk_ins(5'd9, 5'd11); ins_vld_i = 1;
    tick(1);
    pause = 1;
    ins_i = mk_ins(5'd12, 5'd13);
    wb_we_i = 1; wb_addr_i = 5'd9; wb_din_i = 32'h55;
    tick(1);
    wb_we_i = 0;
    #1;
    n_chk++;
    if (rs_o !== 32'h55) begin n_fail++; $display("FAIL hold_refresh: got %h expected 00000055", rs_o); end
    tick(1);
    tick(1);
    pause = 0;
    tick(1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst_i     = ($urandom_range(63) == 0);
      clr_i     = ($urandom_range(15) == 0);
      pause     = ($urandom_range(7) == 0);
      hold_i    = ($urandom_range(7) == 0);
      ins_i     = mk_ins(5'($urandom_range(4)), 5'($urandom_range(4)));
      ins_vld_i = $urandom_range(1);
      wb_we_i   = $urandom_range(1);
      wb_addr_i = 5'($urandom_range(5));
      wb_din_i  = $urandom;
      for (int i = 0; i < NFWD; i++)
        set_fw(i, $urandom_range(1), ($urandom_range(3) == 0), 5'($urandom_range(4)), $urandom);
      tick(1);
    end
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    ins_i = mk_ins(5'd3, 5'd4); ins_vld_i = 1;
    tick(1);
    set_fw(0, 1, 1, 5'd3, 32'h9);
    for (int c = 0; c < 65540; c++) tick(0);
    #1;
    n_chk++;
    if (stall_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL saturate: got %h expected ffff", stall_cnt_o); end
    clr_i = 1;
    tick(0);
    clr_i = 0;
    #1;
    n_chk += 3;
    if (vld_o !== 1'b0) begin n_fail++; $display("FAIL flush_vld: got %b expected 0", vld_o); end
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", stall_o); end
    if (stall_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL flush_cnt: got %h expected ffff", stall_cnt_o); end
    tick(1);
  endtask

  initial begin
    idle();
    m_ins = '0; m_vld = 0; m_rs = '0; m_rt = '0; m_cnt = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    test_reset();
    test_write_through();
    test_fwd_priority();
    test_load_use();
    test_zero_reg();
    test_hold_refresh();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_fetch_p.md
RF_FETCH_P -- requirements
Module: rf_fetch_p

Interface
REQ-001 Parameter DW, default 32: register and operand data width (DW >= 8).
REQ-002 Parameter NFWD, default 2: number of forwarding sources; index 0 is the youngest and has the highest priority.
REQ-003 Parameter ZERO_R0, default 1: when 1, register 0 reads as zero and is never forwarded.
REQ-004 Port clk, input, 1: single clock; all state is updated on the rising edge.
REQ-005 Port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 Port pause, input, 1: global pipeline pause; the stage holds.
REQ-007 Port hold_i, input, 1: controller hold (cls); the stage holds.
REQ-008 Port clr_i, input, 1: flush (clr); loads a bubble.
REQ-009 Port ins_i, input, 32: next instruction from fetch.
REQ-010 Port ins_vld_i, input, 1: ins_i is valid.
REQ-011 Ports wb_we_i (1), wb_addr_i (5), wb_din_i (DW), all inputs: write-back port.
REQ-012 Ports fw_vld_i (NFWD), fw_ld_i (NFWD), fw_addr_i (NFWD*5), fw_data_i (NFWD*DW), all inputs: per-source forwarding valid, data-not-ready flag, destination register and result.
REQ-013 Ports ins_o (32) and vld_o (1), outputs: registered instruction and its valid bit.
REQ-014 Ports rs_n_o and rt_n_o (5 each), outputs: ins_o[25:21] and ins_o[20:16].
REQ-015 Ports rs_o and rt_o (DW each), outputs: forwarded operands.
REQ-016 Port stall_o, output, 1: load-use interlock request to upstream stages.
REQ-017 Port stall_cnt_o, output, 16: saturating count of stall cycles.

Function
REQ-018 Register file: 32 x DW flops with 2 read ports and 1 write port; a write happens at the clock edge when wb_we_i=1, except address 0 when ZERO_R0=1.
REQ-019 Read is synchronous: ins_i[25:21] and ins_i[20:16] are sampled on the same edge that loads ins_o, so rs and rt data align with ins_o with 1-cycle latency.
REQ-020 Write-through on load: if wb_we_i=1 and wb_addr_i equals a sampled read address on the load edge, the captured data is wb_din_i.
REQ-021 Held-data refresh: while the stage holds, a write to rs_n_o or rt_n_o updates the corresponding captured data at that edge.
REQ-022 Stage update priority per edge: rst_i, then clr_i, then hold (pause | hold_i | stall_o), then load.
REQ-023 Load action: ins_o <= ins_i and vld_o <= ins_vld_i.
REQ-024 Clear action: ins_o <= 0 and vld_o <= 0; captured data <= 0.
REQ-025 Hold action: ins_o and vld_o are unchanged.
REQ-026 Forwarding is combinational per operand: select the lowest index i with fw_vld_i[i]=1 and fw_addr_i[i] equal to the operand address; output fw_data_i[i] if found, otherwise the captured data.
REQ-027 When ZERO_R0=1 and the operand address is 0, the operand output is 0 regardless of forwarding.
REQ-028 Interlock: stall_o = vld_o AND, for rs or rt, the selected forwarding source (after priority per REQ-026) has fw_ld_i=1.
REQ-029 A lower-priority source with fw_ld_i=1 that is shadowed by a higher-priority match does not stall.
REQ-030 stall_o is combinational from registered state and the fw inputs; it is never asserted when vld_o=0.
REQ-031 stall_cnt_o increments by 1 on each edge where stall_o=1 and pause=0.
REQ-032 stall_cnt_o saturates at 0xFFFF and does not wrap.
REQ-033 clr_i and stall_o asserted in the same cycle: clear wins, and stall_cnt_o still counts that cycle.

Reset
REQ-034 On the rst_i edge: ins_o=0, vld_o=0, all 32 registers=0, captured data=0, stall_cnt_o=0.
REQ-035 After the reset edge, rs_o=0 and rt_o=0 and stall_o=0 until the first load.
REQ-036 Reset asserted mid-hold or mid-stall overrides all other actions in that cycle.

Verification
REQ-037 Write-through: write r5=0x1234 and load an instruction with rs=5 on the same edge -> rs_o=0x1234 next cycle.
REQ-038 Forward priority: fw0 and fw1 both target r7 (0xAAAA and 0xBBBB) with rs=7 -> rs_o=0xAAAA; drop fw0 -> rs_o=0xBBBB.
REQ-039 Load-use: rt=3, fw0 targets r3 with fw_ld_i=1 for 2 cycles -> stall_o=1 for 2 cycles, ins_o held, stall_cnt_o=2; then rt_o=fw_data_i[0].
REQ-040 Zero register: rs=0 with fw0 targeting r0 at 0xFFFF -> rs_o=0 and stall_o=0.
REQ-041 Hold refresh: pause=1 for 3 cycles while writing r9=0x55 with rs=9 -> rs_o=0x55 after the write edge.
REQ-042 Saturation/flush: force 65,540 stall cycles -> stall_cnt_o=0xFFFF; clr_i during a stall -> vld_o=0 and stall_o=0 next cycle.
